// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, lock-owner
// state encoding and the word-alignment helper.
package dmem_arbiter_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    NO_OWNER = 2'd0,
    OWN0     = 2'd1,
    OWN1     = 2'd2
  } arb_state_t;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/rr_lock_arb.sv
// Round-robin grant generator with lock ownership and a lock-timeout watchdog.
// Grants are combinational; pointer, owner and lock counter are registered.
module rr_lock_arb
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  input  logic lock0_i,
  input  logic lock1_i,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic sel_o,
  output logic timeout0_o,
  output logic timeout1_o
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_LOCK);

  arb_state_t    state_q, state_c, state_d;
  logic          ptr_q, ptr_c, ptr_d;
  logic [CW-1:0] cnt_q, cnt_c, cnt_d;
  logic [CW-1:0] cnt_inc_s;
  logic          gnt0_s, gnt1_s;
  logic          gnt0_g, gnt1_g;
  logic          to0_s, to1_s;

  // Grant selection: an owner excludes the rival, otherwise the pointer breaks ties.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    case (state_q)
      OWN0: begin
        gnt0_s = req0_i;
      end
      OWN1: begin
        gnt1_s = req1_i;
      end
      NO_OWNER: begin
        if (req0_i && req1_i) begin
          gnt0_s = (ptr_q == PORT_CPU);
          gnt1_s = (ptr_q == PORT_DMA);
        end else begin
          gnt0_s = req0_i;
          gnt1_s = req1_i;
        end
      end
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
  end

  assign gnt0_g    = gnt0_s & rst_ni;
  assign gnt1_g    = gnt1_s & rst_ni;
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Ownership and pointer update from this cycle's grant and lock inputs.
  // An owner dropping lock releases even when idle, so a silent owner cannot stall the rival.
  always_comb begin
    state_c = state_q;
    ptr_c   = ptr_q;
    cnt_c   = cnt_q;
    case (state_q)
      NO_OWNER: begin
        if (gnt0_g) begin
          if (lock0_i) begin
            state_c = OWN0;
            cnt_c   = CNT_ONE;
          end else begin
            ptr_c = PORT_DMA;
          end
        end else if (gnt1_g) begin
          if (lock1_i) begin
            state_c = OWN1;
            cnt_c   = CNT_ONE;
          end else begin
            ptr_c = PORT_CPU;
          end
        end else begin
          cnt_c = CNT_ZERO;
        end
      end
      OWN0: begin
        if (lock0_i) begin
          cnt_c = cnt_inc_s;
        end else begin
          state_c = NO_OWNER;
          cnt_c   = CNT_ZERO;
          ptr_c   = PORT_DMA;
        end
      end
      OWN1: begin
        if (lock1_i) begin
          cnt_c = cnt_inc_s;
        end else begin
          state_c = NO_OWNER;
          cnt_c   = CNT_ZERO;
          ptr_c   = PORT_CPU;
        end
      end
      default: begin
        state_c = NO_OWNER;
        cnt_c   = CNT_ZERO;
      end
    endcase
  end

  // Watchdog: a lock whose count reaches the limit is torn down and handed to the rival.
  always_comb begin
    if ((state_c != NO_OWNER) && (cnt_c >= CNT_MAX)) begin
      to0_s   = (state_c == OWN0);
      to1_s   = (state_c == OWN1);
      ptr_d   = (state_c == OWN0) ? PORT_DMA : PORT_CPU;
      state_d = NO_OWNER;
      cnt_d   = CNT_ZERO;
    end else begin
      to0_s   = 1'b0;
      to1_s   = 1'b0;
      ptr_d   = ptr_c;
      state_d = state_c;
      cnt_d   = cnt_c;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= NO_OWNER;
      ptr_q   <= PORT_CPU;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt0_o     = gnt0_g;
  assign gnt1_o     = gnt1_g;
  assign sel_o      = gnt1_g ? PORT_DMA : PORT_CPU;
  assign timeout0_o = to0_s;
  assign timeout1_o = to1_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-ported data memory between the CPU and a
// DMA/debug port, with registered responses, misalignment and lock-timeout errors.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_RD
);

  logic          gnt0_s, gnt1_s, sel_s;
  logic          to0_s, to1_s;
  logic          any_gnt_s, aligned_s, sel_we_s;
  logic [AW-1:0] mem_a_s;
  logic [DW-1:0] mem_wd_s;

  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  rr_lock_arb #(
    .MAX_LOCK(MAX_LOCK)
  ) u_arb (
    .clk_i     (clk),
    .rst_ni    (rst),
    .req0_i    (req0),
    .req1_i    (req1),
    .lock0_i   (lock0),
    .lock1_i   (lock1),
    .gnt0_o    (gnt0_s),
    .gnt1_o    (gnt1_s),
    .sel_o     (sel_s),
    .timeout0_o(to0_s),
    .timeout1_o(to1_s)
  );

  // Memory-side mux: the granted port drives address and data, port 0 when idle.
  always_comb begin
    if (sel_s == PORT_DMA) begin
      mem_a_s  = addr1;
      mem_wd_s = wdata1;
      sel_we_s = we1;
    end else begin
      mem_a_s  = addr0;
      mem_wd_s = wdata0;
      sel_we_s = we0;
    end
  end

  assign any_gnt_s = gnt0_s | gnt1_s;
  assign aligned_s = word_aligned(mem_a_s[1:0]);

  // Response next-state: data only for aligned reads, errors for misalignment or timeout.
  always_comb begin
    rvalid0_d = gnt0_s;
    rvalid1_d = gnt1_s;
    err0_d    = (gnt0_s & ~aligned_s) | to0_s;
    err1_d    = (gnt1_s & ~aligned_s) | to1_s;
    if (any_gnt_s && !sel_we_s && aligned_s) begin
      rdata0_d = gnt0_s ? mem_RD : {DW{1'b0}};
      rdata1_d = gnt1_s ? mem_RD : {DW{1'b0}};
    end else begin
      rdata0_d = {DW{1'b0}};
      rdata1_d = {DW{1'b0}};
    end
  end

  // Response registers; reset drops any pending response at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= {DW{1'b0}};
      rdata1_q  <= {DW{1'b0}};
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign gnt0    = gnt0_s;
  assign gnt1    = gnt1_s;
  assign mem_A   = mem_a_s;
  assign mem_WD  = mem_wd_s;
  assign mem_WE  = any_gnt_s & sel_we_s & aligned_s;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a behavioural model
// of arbitration, locking, timeout and memory contents.
module tb_dmem_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_LOCK = 4;
  localparam int NWORDS   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_WD, mem_RD;
  logic          mem_WE;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 4) ? 32'hCAFE_BABE : (32'h1000_0000 + 32'(i));
  endfunction

  // Memory: combinational read, synchronous write, preloaded before traffic starts.
  logic [DW-1:0] mem [NWORDS];
  logic          mem_ready;
  assign mem_RD = mem[mem_A[5:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= init_word(i);
    end else if (mem_WE) begin
      mem[mem_A[5:2]] <= mem_WD;
    end
  end

  // Reference model state
  int            owner, prefer, held;
  logic [DW-1:0] ref_mem [NWORDS];
  logic          exp_rv [2];
  logic          exp_err [2];
  logic [DW-1:0] exp_rd [2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic reset_model();
    owner  = -1;
    prefer = 0;
    held   = 0;
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = 1'b0; exp_err[p] = 1'b0; exp_rd[p] = '0;
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w, input logic l,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    end
  endtask

  // One cycle: called at a negedge with inputs applied; returns at the next negedge.
  task automatic step();
    int            g, idx;
    logic          al;
    logic          r [2], w [2], l [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic          nrv [2], nerr [2];
    logic [DW-1:0] nrd [2];
    r[0] = req0; r[1] = req1; w[0] = we0; w[1] = we1; l[0] = lock0; l[1] = lock1;
    a[0] = addr0; a[1] = addr1; d[0] = wdata0; d[1] = wdata1;
    #1;
    g = -1;
    if (rst) begin
      if (owner >= 0) begin
        if (r[owner]) g = owner;
      end else if (r[0] && r[1]) g = prefer;
      else if (r[0]) g = 0;
      else if (r[1]) g = 1;
    end
    al = (g >= 0) ? (a[g][1:0] == 2'b00) : 1'b1;
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("mem_A", mem_A, (g == 1) ? a[1] : a[0]);
    chk("mem_WD", mem_WD, (g == 1) ? d[1] : d[0]);
    chk("mem_WE", 32'(mem_WE), 32'(g >= 0 && w[g] && al));
    chk("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
    chk("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
    chk("err0", 32'(err0), 32'(exp_err[0]));
    chk("err1", 32'(err1), 32'(exp_err[1]));
    chk("rdata0", rdata0, exp_rd[0]);
    chk("rdata1", rdata1, exp_rd[1]);
    for (int p = 0; p < 2; p++) begin
      nrv[p] = 1'b0; nerr[p] = 1'b0; nrd[p] = '0;
    end
    if (g >= 0) begin
      idx    = int'(a[g][5:2]);
      nrv[g] = 1'b1;
      if (!al) nerr[g] = 1'b1;
      else if (w[g]) ref_mem[idx] = d[g];
      else nrd[g] = ref_mem[idx];
    end
    if (owner < 0) begin
      if (g >= 0) begin
        if (l[g]) begin
          owner = g; held = 1;
        end else prefer = 1 - g;
      end
    end else if (l[owner]) begin
      held++;
    end else begin
      prefer = 1 - owner; owner = -1; held = 0;
    end
    if (owner >= 0 && held >= MAX_LOCK) begin
      nerr[owner] = 1'b1; prefer = 1 - owner; owner = -1; held = 0;
    end
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = nrv[p]; exp_err[p] = nerr[p]; exp_rd[p] = nrd[p];
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);
    rst = 1'b0; mem_ready = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    reset_model();

    // Requests during reset are neither granted nor written
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_0000);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h4, 32'hDEAD_0001);
    step();
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step();

    // Both ports writing: grants alternate starting at port 0
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hA000_0000 + 32'(i));
      drive(1, 1'b1, 1'b1, 1'b0, 32'h4, 32'hB000_0000 + 32'(i));
      #1 chk("alt_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      step();
    end
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("alt_mem0", mem[0], 32'hA000_0002);
    chk("alt_mem1", mem[1], 32'hB000_0003);

    // Single read of word 4
    drive(0, 1'b1, 1'b0, 1'b0, 32'h10, '0);
    step();
    chk("rd_rvalid0", 32'(rvalid0), 32'd1);
    chk("rd_rdata0", rdata0, 32'hCAFE_BABE);
    chk("rd_err0", 32'(err0), 32'd0);

    // Port 1 locked for three reads, then releases; port 0 waits throughout
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b0, 1'b0, 32'h8, '0);
      drive(1, 1'b1, 1'b0, (i < 3), 32'h20 + 32'(4 * i), '0);
      #1 chk("lk_gnt1", 32'({gnt1, gnt0}), 32'd2);
      step();
    end
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1 chk("lk_rel_gnt0", 32'(gnt0), 32'd1);
    step();

    // Port 0 holds the lock until the watchdog fires, port 1 pending
    drive(0, 1'b1, 1'b0, 1'b1, 32'h14, '0);
    step();
    drive(1, 1'b1, 1'b0, 1'b0, 32'h18, '0);
    for (int i = 1; i < MAX_LOCK; i++) step();
    chk("to_err0", 32'(err0), 32'd1);
    chk("to_rvalid0", 32'(rvalid0), 32'd1);
    #1 chk("to_gnt1", 32'(gnt1), 32'd1);
    step();
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step();
    drive(0, 1'b1, 1'b0, 1'b0, 32'h14, '0);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    step();

    // Misaligned write is granted but suppressed
    drive(1, 1'b1, 1'b1, 1'b0, 32'h6, 32'h0000_1234);
    #1 chk("mis_gnt1", 32'(gnt1), 32'd1);
    chk("mis_we", 32'(mem_WE), 32'd0);
    step();
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("mis_err1", 32'({err1, rvalid1}), 32'd3);
    chk("mis_mem1", mem[1], 32'hB000_0003);

    // Reset one cycle after a read grant
    drive(0, 1'b1, 1'b0, 1'b0, 32'h10, '0);
    step();
    chk("mid_rvalid0_pre", 32'(rvalid0), 32'd1);
    rst = 1'b0;
    #1 chk("mid_rvalid0", 32'(rvalid0), 32'd0);
    chk("mid_rdata0", rdata0, 32'd0);
    reset_model();
    drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h5555_AAAA);
    step();
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 32'h10, '0);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h14, '0);
    #1 chk("mid_restart_gnt0", 32'(gnt0), 32'd1);
    step();

    // Randomized traffic; an owner mostly keeps its lock so timeouts occur
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        logic [AW-1:0] a;
        a = 32'($urandom_range(0, NWORDS - 1)) << 2;
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        drive(p, ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
              (owner == p) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 3),
              a, $urandom);
      end
      step();
    end
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step();

    for (int i = 0; i < NWORDS; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
